// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: owns the fetch PC, keeps pipelined in-order imem requests under a credit
// rule and buffers the responses in a DEPTH-entry FIFO for decode. Optional: IFQ_BYPASS_EN.

module instr_fetch_queue_chk #(
  parameter int OUT_W = 2,
  parameter int CNT_W = 3,
  parameter int DEPTH = 4
) (
  input logic             clk,
  input logic             rst,
  input logic             imem_rsp_valid,
  input logic [OUT_W-1:0] outstanding,
  input logic             push,
  input logic [CNT_W-1:0] occupancy
);
  rsp_without_request: assert property (@(posedge clk) disable iff (rst)
    imem_rsp_valid |-> (outstanding != OUT_W'(0)));
  push_into_full_fifo: assert property (@(posedge clk) disable iff (rst)
    push |-> (occupancy != CNT_W'(DEPTH)));
endmodule

module instr_fetch_queue #(
  parameter int              XLEN         = 32,
  parameter int              DEPTH        = 4,
  parameter int              MAX_INFLIGHT = 2,
  parameter logic [XLEN-1:0] RESET_PC     = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       imem_req_valid,
  input  logic                       imem_req_ready,
  output logic [XLEN-1:0]            imem_req_addr,
  input  logic                       imem_rsp_valid,
  input  logic [31:0]                imem_rsp_data,
  input  logic                       redirect_valid,
  input  logic [XLEN-1:0]            redirect_pc,
  output logic                       instr_valid,
  input  logic                       instr_ready,
  output logic [31:0]                instr_data,
  output logic [XLEN-1:0]            instr_pc,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int OUT_W = $clog2(MAX_INFLIGHT + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int SUM_W = CNT_W + OUT_W;

  logic [XLEN-1:0]  pc_q, pc_d, rsp_pc_q, rsp_pc_d;
  logic [OUT_W-1:0] outstanding_q, outstanding_d, drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [31:0]      data_mem_q [DEPTH];
  logic [XLEN-1:0]  pc_mem_q [DEPTH];

  logic             accept_s, rsp_fresh_s, bypass_s, push_s, pop_s, fifo_empty_s;
  logic [SUM_W-1:0] credit_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return PTR_W'(0);
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  // Credit rule: queued words plus words in flight never exceed the FIFO size.
  assign fifo_empty_s   = (count_q == CNT_W'(0));
  assign credit_s       = SUM_W'(count_q) + SUM_W'(outstanding_q);
  assign imem_req_valid = !rst && !redirect_valid
                          && (outstanding_q < OUT_W'(MAX_INFLIGHT))
                          && (credit_s < SUM_W'(DEPTH));
  assign imem_req_addr  = pc_q;
  assign accept_s       = imem_req_valid && imem_req_ready;
  assign rsp_fresh_s    = !rst && imem_rsp_valid && !redirect_valid && (drop_cnt_q == OUT_W'(0));

`ifdef IFQ_BYPASS_EN
  assign bypass_s = rsp_fresh_s && fifo_empty_s;
`else
  assign bypass_s = 1'b0;
`endif

  assign instr_valid = !redirect_valid && (!fifo_empty_s || bypass_s);
  assign instr_data  = bypass_s ? imem_rsp_data : data_mem_q[rd_ptr_q];
  assign instr_pc    = bypass_s ? rsp_pc_q : pc_mem_q[rd_ptr_q];
  assign occupancy   = count_q;
  assign pop_s       = instr_valid && instr_ready && !fifo_empty_s;
  assign push_s      = rsp_fresh_s && !(bypass_s && instr_ready);

  // Next-state: a redirect overrides every other update in the same cycle.
  always_comb begin
    pc_d          = pc_q;
    rsp_pc_d      = rsp_pc_q;
    outstanding_d = outstanding_q;
    drop_cnt_d    = drop_cnt_q;
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    if (redirect_valid) begin
      pc_d          = redirect_pc;
      rsp_pc_d      = redirect_pc;
      outstanding_d = outstanding_q - OUT_W'(imem_rsp_valid);
      drop_cnt_d    = outstanding_q - OUT_W'(imem_rsp_valid);
      count_d       = CNT_W'(0);
      rd_ptr_d      = PTR_W'(0);
      wr_ptr_d      = PTR_W'(0);
    end else begin
      if (accept_s) begin
        pc_d = pc_q + XLEN'(4);
      end else begin
        pc_d = pc_q;
      end
      outstanding_d = outstanding_q + OUT_W'(accept_s) - OUT_W'(imem_rsp_valid);
      if (imem_rsp_valid && (drop_cnt_q != OUT_W'(0))) begin
        drop_cnt_d = drop_cnt_q - OUT_W'(1);
      end else begin
        drop_cnt_d = drop_cnt_q;
      end
      if (rsp_fresh_s) begin
        rsp_pc_d = rsp_pc_q + XLEN'(4);
      end else begin
        rsp_pc_d = rsp_pc_q;
      end
      if (push_s) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      count_d = count_q + CNT_W'(push_s) - CNT_W'(pop_s);
    end
  end

  // State and FIFO storage; storage is cleared so outputs read zero in reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= OUT_W'(0);
      drop_cnt_q    <= OUT_W'(0);
      count_q       <= CNT_W'(0);
      rd_ptr_q      <= PTR_W'(0);
      wr_ptr_q      <= PTR_W'(0);
      for (int i = 0; i < DEPTH; i++) begin
        data_mem_q[i] <= 32'h0;
        pc_mem_q[i]   <= XLEN'(0);
      end
    end else begin
      pc_q          <= pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      if (push_s) begin
        data_mem_q[wr_ptr_q] <= imem_rsp_data;
        pc_mem_q[wr_ptr_q]   <= rsp_pc_q;
      end else begin
        data_mem_q[wr_ptr_q] <= data_mem_q[wr_ptr_q];
        pc_mem_q[wr_ptr_q]   <= pc_mem_q[wr_ptr_q];
      end
    end
  end

  instr_fetch_queue_chk #(.OUT_W(OUT_W), .CNT_W(CNT_W), .DEPTH(DEPTH)) u_chk (
    .clk            (clk),
    .rst            (rst),
    .imem_rsp_valid (imem_rsp_valid),
    .outstanding    (outstanding_q),
    .push           (push_s),
    .occupancy      (count_q)
  );
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Randomized bench for instr_fetch_queue: an imem model with variable latency plus a queue-level
// reference of which fetched words must reach decode, in which order and with which PC.

module tb_instr_fetch_queue;
  localparam int          DEPTH        = 4;
  localparam int          MAX_INFLIGHT = 2;
  localparam logic [31:0] RESET_PC     = 32'h0000_0100;
`ifdef IFQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid, instr_ready;
  logic [31:0] instr_data, instr_pc;
  logic [2:0]  occupancy;

  always #5 clk = ~clk;

  instr_fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .MAX_INFLIGHT(MAX_INFLIGHT), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_data(instr_data),
    .instr_pc(instr_pc), .occupancy(occupancy)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } req_t;

  req_t        imem_q[$];     // accepted requests awaiting their response
  logic [31:0] fifo_m[$];     // PCs of words that decode has yet to receive
  logic [31:0] dq[$];         // PCs delivered since the last redirect
  logic [31:0] exp_fetch, last_redir_pc;
  int          cyc, n_checks, n_errors, n_delivered, redir_hits;
  int          p_ready, p_req_ready, p_redirect, lat_min, lat_max;
  bit          force_redir, redir_on_rsp;
  logic [31:0] force_pc;
  logic [31:0] s_occ, s_rv;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC3A5_5A3C;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1; redirect_valid = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    instr_ready = 1'b0; imem_req_ready = 1'b0; redirect_pc = 32'h0;
    imem_q.delete(); fifo_m.delete(); dq.delete();
    exp_fetch = RESET_PC;
    for (int i = 0; i < n; i++) begin
      #1;
      check_eq("rst_req_valid", 32'(imem_req_valid), 32'h0);
      check_eq("rst_req_addr", imem_req_addr, RESET_PC);
      check_eq("rst_instr_valid", 32'(instr_valid), 32'h0);
      check_eq("rst_instr_data", instr_data, 32'h0);
      check_eq("rst_instr_pc", instr_pc, 32'h0);
      check_eq("rst_occupancy", 32'(occupancy), 32'h0);
      @(negedge clk);
    end
    rst = 1'b0;
  endtask

  task automatic step();
    bit          redir, rsp_v, rsp_stale, fresh, bypass, exp_iv, exp_rv;
    logic [31:0] rsp_addr, head_pc;
    int          out_n;
    req_t        r;
    @(negedge clk);
    rsp_v = 1'b0; rsp_stale = 1'b0; rsp_addr = 32'h0;
    out_n = imem_q.size();
    if (imem_q.size() > 0 && imem_q[0].due <= cyc) begin
      r = imem_q.pop_front();
      rsp_v = 1'b1; rsp_addr = r.addr; rsp_stale = r.stale;
    end
    redir = force_redir || ($urandom_range(0, 99) < p_redirect);
    instr_ready = ($urandom_range(0, 99) < p_ready);
    if (redir_on_rsp && rsp_v && fifo_m.size() > 0) begin
      redir = 1'b1; instr_ready = 1'b1; redir_on_rsp = 1'b0; redir_hits++;
    end
    imem_req_ready = ($urandom_range(0, 99) < p_req_ready);
    redirect_valid = redir;
    redirect_pc    = force_redir ? force_pc : ($urandom() & 32'hFFFF_FFFC);
    imem_rsp_valid = rsp_v;
    imem_rsp_data  = rsp_v ? word_of(rsp_addr) : $urandom();
    #1;
    fresh  = rsp_v && !rsp_stale && !redir;
    bypass = BYP && fresh && (fifo_m.size() == 0);
    exp_iv = !redir && (fifo_m.size() > 0 || bypass);
    exp_rv = !redir && (out_n < MAX_INFLIGHT) && (fifo_m.size() + out_n < DEPTH);
    s_occ = 32'(occupancy); s_rv = 32'(imem_req_valid);
    check_eq("occupancy", 32'(occupancy), 32'(fifo_m.size()));
    check_eq("req_valid", 32'(imem_req_valid), 32'(exp_rv));
    check_eq("instr_valid", 32'(instr_valid), 32'(exp_iv));
    if (exp_iv) begin
      head_pc = (fifo_m.size() > 0) ? fifo_m[0] : rsp_addr;
      check_eq("instr_pc", instr_pc, head_pc);
      check_eq("instr_data", instr_data, word_of(head_pc));
    end
    if (imem_req_valid) check_eq("req_addr", imem_req_addr, exp_fetch);
    if (redir) begin
      fifo_m.delete(); dq.delete();
      foreach (imem_q[i]) imem_q[i].stale = 1'b1;
      exp_fetch = redirect_pc; last_redir_pc = redirect_pc;
    end else begin
      if (exp_iv && instr_ready) begin
        dq.push_back((fifo_m.size() > 0) ? fifo_m[0] : rsp_addr);
        if (fifo_m.size() > 0) void'(fifo_m.pop_front());
        n_delivered++;
      end
      if (fresh && !(bypass && instr_ready)) fifo_m.push_back(rsp_addr);
    end
    if (imem_req_valid && imem_req_ready) begin
      r.addr = imem_req_addr; r.due = cyc + $urandom_range(lat_min, lat_max); r.stale = 1'b0;
      imem_q.push_back(r);
      exp_fetch = exp_fetch + 32'd4;
    end
    cyc++;
  endtask

  initial begin
    n_checks = 0; n_errors = 0; n_delivered = 0; redir_hits = 0; cyc = 0;
    force_redir = 1'b0; redir_on_rsp = 1'b0; force_pc = 32'h0; last_redir_pc = 32'h0;
    p_ready = 100; p_req_ready = 100; p_redirect = 0; lat_min = 1; lat_max = 1;

    // Straight-line fetch from RESET_PC with a 1-cycle memory.
    do_reset(3);
    repeat (30) step();

    // Decode stalled: the queue fills to DEPTH and fetch stops, then drains in order.
    p_ready = 0;
    repeat (20) step();
    check_eq("bp_occupancy", s_occ, 32'(DEPTH));
    check_eq("bp_req_valid", s_rv, 32'h0);
    p_ready = 100;
    repeat (30) step();

    // Redirect with two requests in flight on a 3-cycle memory.
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 20 && imem_q.size() < 2; i++) step();
    check_eq("two_outstanding", 32'(imem_q.size()), 32'd2);
    force_redir = 1'b1; force_pc = 32'h0000_2000;
    step();
    force_redir = 1'b0;
    repeat (30) step();
    check_eq("redir_first_pc", (dq.size() > 0) ? dq[0] : 32'hDEAD_BEEF, 32'h0000_2000);

    // Redirect landing on a response and a would-be pop.
    lat_min = 1; lat_max = 3; redir_on_rsp = 1'b1;
    for (int i = 0; i < 60 && redir_on_rsp; i++) step();
    check_eq("redir_on_rsp_hit", 32'(redir_hits), 32'd1);
    repeat (30) step();
    check_eq("redir_rsp_first_pc", (dq.size() > 0) ? dq[0] : ~last_redir_pc, last_redir_pc);

    // Address wrap past 2^32.
    lat_min = 1; lat_max = 1; force_redir = 1'b1; force_pc = 32'hFFFF_FFFC;
    step();
    force_redir = 1'b0;
    repeat (20) step();
    check_eq("wrap_first_pc", (dq.size() > 0) ? dq[0] : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
    check_eq("wrap_second_pc", (dq.size() > 1) ? dq[1] : 32'hDEAD_BEEF, 32'h0000_0000);

    // Randomized traffic with redirects, variable latency and one mid-run reset.
    for (int w = 0; w < 30; w++) begin
      p_ready = $urandom_range(30, 100); p_req_ready = $urandom_range(40, 100);
      p_redirect = $urandom_range(0, 5); lat_min = 1; lat_max = $urandom_range(1, 4);
      if (w == 15) do_reset(2);
      repeat (100) step();
    end
    check_eq("progress", 32'(n_delivered > 300), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
